// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_if
// Description : Channel-side result handshake and common-data-bus broadcast
//               bundle for the CDB arbiter. The slave modport is the arbiter
//               view; the master modport is the execution-unit/consumer view.
// Revision    : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if #(
   parameter int N_CH   = 4,
   parameter int W_DATA = 32,
   parameter int W_TAG  = 6
);
   localparam int c_W_CH = $clog2(N_CH);

   // Channel result side (flattened, channel i at [i*W +: W])
   logic [N_CH-1:0]        ch_valid;
   logic [N_CH-1:0]        ch_ready;
   logic [N_CH*W_TAG-1:0]  ch_tag;
   logic [N_CH*W_DATA-1:0] ch_data;
   logic [N_CH-1:0]        ch_branch;
   logic [N_CH-1:0]        ch_branch_taken;

   // Broadcast side
   logic                   cdb_valid;
   logic [W_TAG-1:0]       cdb_tag;
   logic [W_DATA-1:0]      cdb_data;
   logic                   cdb_branch;
   logic                   cdb_branch_taken;
   logic [c_W_CH-1:0]      cdb_grant_ch;

   modport slave (
      input  ch_valid,
      input  ch_tag,
      input  ch_data,
      input  ch_branch,
      input  ch_branch_taken,
      output ch_ready,
      output cdb_valid,
      output cdb_tag,
      output cdb_data,
      output cdb_branch,
      output cdb_branch_taken,
      output cdb_grant_ch
   );

   modport master (
      output ch_valid,
      output ch_tag,
      output ch_data,
      output ch_branch,
      output ch_branch_taken,
      input  ch_ready,
      input  cdb_valid,
      input  cdb_tag,
      input  cdb_data,
      input  cdb_branch,
      input  cdb_branch_taken,
      input  cdb_grant_ch
   );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Parametrised common-data-bus arbiter. Each execution channel
//               owns a one-entry result buffer; one buffered result per cycle
//               is granted round-robin and broadcast on a registered CDB.
//               A synchronous flush kills all buffered results and the CDB.
//               Optional macro CDB_STALL_STATS_EN adds a saturating 16-bit
//               stall_cnt output counting cycles with a full, ungranted buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
   parameter int N_CH   = 4,
   parameter int W_DATA = 32,
   parameter int W_TAG  = 6
) (
   input  logic        clk,
   input  logic        reset,      // asynchronous, active-low
   input  logic        flush,
`ifdef CDB_STALL_STATS_EN
   output logic [15:0] stall_cnt,
`endif
   cdb_arbiter_if.slave bus
);

   localparam int                 c_W_CH = $clog2(N_CH);
   localparam logic [c_W_CH:0]    c_N_CH = (c_W_CH+1)'(N_CH);
   localparam logic [c_W_CH-1:0]  c_LAST = c_W_CH'(N_CH - 1);
   localparam logic [c_W_CH-1:0]  c_ONE  = c_W_CH'(1);
   localparam logic [N_CH-1:0]    c_BIT0 = N_CH'(1);

   // Per-channel one-entry result buffers
   logic [N_CH-1:0]   r_buf_full;
   logic [W_TAG-1:0]  r_buf_tag  [N_CH];
   logic [W_DATA-1:0] r_buf_data [N_CH];
   logic [N_CH-1:0]   r_buf_branch;
   logic [N_CH-1:0]   r_buf_taken;

   // Round-robin pointer: channel with highest priority this cycle
   logic [c_W_CH-1:0] r_rr_ptr;

   // Registered broadcast
   logic              r_cdb_valid;
   logic [W_TAG-1:0]  r_cdb_tag;
   logic [W_DATA-1:0] r_cdb_data;
   logic              r_cdb_branch;
   logic              r_cdb_taken;
   logic [c_W_CH-1:0] r_cdb_grant_ch;

   // Arbitration wires
   logic              w_grant_valid;
   logic [c_W_CH-1:0] w_grant_idx;
   logic [N_CH-1:0]   w_grant;
   logic [c_W_CH-1:0] w_rr_next;
   logic [c_W_CH:0]   w_rr_sum;
   logic [N_CH-1:0]   w_ready;
   logic [N_CH-1:0]   w_accept;

   // Round-robin search: walk from r_rr_ptr, wrapping modulo N_CH, first full wins
   always_comb begin
      w_grant_valid = 1'b0;
      w_grant_idx   = '0;
      w_rr_sum      = '0;
      for (int k = 0; k < N_CH; k++) begin
         w_rr_sum = {1'b0, r_rr_ptr} + (c_W_CH+1)'(k);
         if (w_rr_sum >= c_N_CH) begin
            w_rr_sum = w_rr_sum - c_N_CH;
         end
         if (!w_grant_valid && r_buf_full[w_rr_sum[c_W_CH-1:0]]) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = w_rr_sum[c_W_CH-1:0];
         end
      end
   end

   // One-hot grant, next pointer, and the ready/accept handshake.
   // A granted channel frees its slot this cycle, so it may reload immediately;
   // flush blocks every accept so nothing survives the kill.
   assign w_grant   = w_grant_valid ? (c_BIT0 << w_grant_idx) : '0;
   assign w_rr_next = (w_grant_idx == c_LAST) ? '0 : (w_grant_idx + c_ONE);
   assign w_ready   = flush ? '0 : (~r_buf_full | w_grant);
   assign w_accept  = bus.ch_valid & w_ready;

   // Result buffers: flush clears, accept loads (winning over a same-cycle grant), grant drains
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_buf_full   <= '0;
         r_buf_branch <= '0;
         r_buf_taken  <= '0;
         for (int i = 0; i < N_CH; i++) begin
            r_buf_tag[i]  <= '0;
            r_buf_data[i] <= '0;
         end
      end else if (flush) begin
         r_buf_full <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (w_accept[i]) begin
               r_buf_full[i]   <= 1'b1;
               r_buf_tag[i]    <= bus.ch_tag[i*W_TAG +: W_TAG];
               r_buf_data[i]   <= bus.ch_data[i*W_DATA +: W_DATA];
               r_buf_branch[i] <= bus.ch_branch[i];
               r_buf_taken[i]  <= bus.ch_branch_taken[i];
            end else if (w_grant[i]) begin
               r_buf_full[i] <= 1'b0;
            end
         end
      end
   end

   // CDB register and round-robin pointer: load the winner, otherwise drop valid and hold payload
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cdb_valid    <= 1'b0;
         r_cdb_tag      <= '0;
         r_cdb_data     <= '0;
         r_cdb_branch   <= 1'b0;
         r_cdb_taken    <= 1'b0;
         r_cdb_grant_ch <= '0;
         r_rr_ptr       <= '0;
      end else if (flush) begin
         r_cdb_valid <= 1'b0;
         r_rr_ptr    <= '0;
      end else if (w_grant_valid) begin
         r_cdb_valid    <= 1'b1;
         r_cdb_tag      <= r_buf_tag[w_grant_idx];
         r_cdb_data     <= r_buf_data[w_grant_idx];
         r_cdb_branch   <= r_buf_branch[w_grant_idx];
         r_cdb_taken    <= r_buf_taken[w_grant_idx];
         r_cdb_grant_ch <= w_grant_idx;
         r_rr_ptr       <= w_rr_next;
      end else begin
         r_cdb_valid <= 1'b0;
      end
   end

   assign bus.ch_ready         = w_ready;
   assign bus.cdb_valid        = r_cdb_valid;
   assign bus.cdb_tag          = r_cdb_tag;
   assign bus.cdb_data         = r_cdb_data;
   assign bus.cdb_branch       = r_cdb_branch;
   assign bus.cdb_branch_taken = r_cdb_taken;
   assign bus.cdb_grant_ch     = r_cdb_grant_ch;

`ifdef CDB_STALL_STATS_EN
   logic [15:0] r_stall_cnt;
   logic        w_stall;

   // A stall is any buffered result left waiting behind this cycle's winner
   assign w_stall = |(r_buf_full & ~w_grant);

   // Saturating stall counter; only reset clears it so stats survive flushes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
